// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the lab ALU datapath and its sequencer.
//   alu_op_e          : 2-bit ALU opcode (AND, OR, ADD, SUB)
//   alu_ctrl_state_e  : sequencer FSM states
//   ALU_RES_W         : width of the ALU result bus
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_RES_W = 16;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } alu_ctrl_state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Sequences one ALU operation at a time: accepts a request, holds the operands
// on the ALU inputs, pulses start, waits (bounded) for the ALU result, and
// presents the registered result on a valid/ready response port.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake
//   req_a, req_b, req_op    : request operands (N bits) and opcode
//   alu_a, alu_b, alu_op    : operands/opcode held on the ALU inputs
//   alu_start               : one-cycle start pulse to the ALU
//   alu_result, alu_valid   : ALU result and its valid flag
//   rsp_valid/rsp_ready     : response handshake
//   rsp_result, rsp_err     : registered result, timeout flag
//   op_count                : successful responses consumed (wraps)
//
// State | Meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a request; operands of the last op still held
// ISSUE | start pulse on the ALU
// WAIT  | sampling alu_valid, timer counts toward TIMEOUT
// RESP  | response presented until consumed
// -----------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int N       = 7,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [N-1:0]         req_a,
    input  logic [N-1:0]         req_b,
    input  logic [1:0]           req_op,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic [1:0]           alu_op,
    output logic                 alu_start,
    input  logic [ALU_RES_W-1:0] alu_result,
    input  logic                 alu_valid,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ALU_RES_W-1:0] rsp_result,
    output logic                 rsp_err,
    output logic [15:0]          op_count
);

    localparam int              TMR_W    = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    alu_ctrl_state_e        state_q, state_d;
    logic [N-1:0]           alu_a_q, alu_a_d;
    logic [N-1:0]           alu_b_q, alu_b_d;
    alu_op_e                alu_op_q, alu_op_d;
    logic                   alu_start_q, alu_start_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ALU_RES_W-1:0]   rsp_result_q, rsp_result_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [15:0]            op_count_q, op_count_d;
    logic [TMR_W-1:0]       timer_q, timer_d;

    // All outputs are flops: the next-state logic computes their values for
    // the state being entered, so nothing downstream sees a combinational path.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_start_d  = 1'b0;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;
        timer_d      = timer_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_a_d     = req_a;
                    alu_b_d     = req_b;
                    alu_op_d    = alu_op_e'(req_op);
                    timer_d     = '0;
                    alu_start_d = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // alu_valid is deliberately not looked at here
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_valid) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (timer_q == TMR_LAST) begin
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                    if (!rsp_err_q) begin
                        op_count_d = op_count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_AND;
            alu_start_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_start_q  <= alu_start_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
            timer_q      <= timer_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_start  = alu_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Self-checking bench for alu_seq_ctrl. The bench plays the ALU (result from
// plain arithmetic on the held operands, valid after a programmable number of
// WAIT cycles or never), a stimulus process issues requests and pushes the
// predicted response into a queue, and a monitor pops and compares on every
// response handshake.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int N       = 7;
    localparam int TIMEOUT = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid;
    logic          req_ready;
    logic [N-1:0]  req_a, req_b;
    logic [1:0]    req_op;
    logic [N-1:0]  alu_a, alu_b;
    logic [1:0]    alu_op;
    logic          alu_start;
    logic [15:0]   alu_result;
    logic          alu_valid;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_result;
    logic          rsp_err;
    logic [15:0]   op_count;

    alu_seq_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_valid(alu_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    function automatic logic [15:0] alu_ref(input int a, input int b, input int op);
        case (op)
            0:       return 16'(a & b);
            1:       return 16'(a | b);
            2:       return 16'(a + b);
            default: return 16'(a - b);
        endcase
    endfunction

    typedef struct packed {
        logic        err;
        logic [15:0] res;
    } exp_t;

    // lat < 0 means the ALU never answers
    function automatic exp_t predict(input int a, input int b, input int op, input int lat);
        exp_t e;
        if (lat >= 0 && lat < TIMEOUT) begin
            e.err = 1'b0;
            e.res = alu_ref(a, b, op);
        end else begin
            e.err = 1'b0 | 1'b1;
            e.res = 16'h0000;
        end
        return e;
    endfunction

    // ---------------- bench ALU ----------------
    int   lat_cfg = 0;
    logic valid_hi = 1'b0;
    logic issue_pulse = 1'b0;
    logic busy;
    int   wcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            wcnt <= 0;
        end else if (alu_start) begin
            busy <= 1'b1;
            wcnt <= 0;
        end else if (rsp_valid) begin
            busy <= 1'b0;
        end else if (busy) begin
            wcnt <= wcnt + 1;
        end
    end

    assign alu_result = alu_ref(int'(alu_a), int'(alu_b), int'(alu_op));
    assign alu_valid  = valid_hi | (issue_pulse & alu_start) |
                        (busy && lat_cfg >= 0 && wcnt >= lat_cfg);

    // ---------------- response ready ----------------
    logic rand_ready = 1'b0;
    logic rr_rand    = 1'b1;
    logic rr_dir     = 1'b1;
    assign rsp_ready = rand_ready ? rr_rand : rr_dir;

    initial forever begin
        @(posedge clk);
        #1;
        rr_rand = ($urandom_range(0, 3) != 0);
    end

    // ---------------- scoreboard ----------------
    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_cnt = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        logic        prev_v, prev_hs, prev_err, hs;
        logic [15:0] prev_res;
        exp_t        e;
        prev_v = 1'b0; prev_hs = 1'b0; prev_err = 1'b0; prev_res = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v && !prev_hs) begin
                    check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                    check("rsp_hold_data", 32'({rsp_err, rsp_result}), 32'({prev_err, prev_res}));
                end
                hs = rsp_valid && rsp_ready;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_result", 32'(rsp_result), 32'(e.res));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("op_count", 32'(op_count), 32'(model_cnt));
                        if (!e.err) model_cnt = model_cnt + 16'd1;
                    end
                end
                prev_v   = rsp_valid;
                prev_hs  = hs;
                prev_err = rsp_err;
                prev_res = rsp_result;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns one step after the accepting edge (cycle 1), acc = cyc then.
    task automatic send(input int a, input int b, input int op, input int lat, output int acc);
        int guard;
        req_a = N'(a); req_b = N'(b); req_op = 2'(op); req_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!req_ready && guard < 200);
        if (!req_ready) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        lat_cfg = lat;
        exp_q.push_back(predict(a, b, op, lat));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || !req_ready) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : stim
        int acc, acc2, c0, k;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_op = 2'b00;

        // reset values, checked without any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_alu_ops", 32'({alu_a, alu_b, alu_op, alu_start}), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_result}), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // basic ADD with minimum latency
        valid_hi = 1'b1;
        send(100, 27, 2, 0, acc);
        check("add_start_c1", 32'(alu_start), 32'd1);
        check("add_operands", 32'({alu_a, alu_b, alu_op}), 32'({7'd100, 7'd27, 2'b10}));
        @(posedge clk); #1;
        check("add_start_c2", 32'(alu_start), 32'd0);
        check("add_novalid_c2", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("add_valid_c3", 32'(rsp_valid), 32'd1);
        check("add_result_c3", 32'(rsp_result), 32'd127);
        @(posedge clk); #1;
        check("add_op_count", 32'(op_count), 32'd1);
        check("add_hold_idle", 32'({req_ready, alu_a, alu_b}), 32'({1'b1, 7'd100, 7'd27}));
        valid_hi = 1'b0;

        // SUB wrap, AND, OR; back-to-back throughput
        send(3, 5, 3, 0, acc);
        send(7'h55, 7'h0F, 0, 0, acc);
        send(7'h55, 7'h0F, 1, 0, acc2);
        check("throughput", 32'(acc2 - acc), 32'd4);
        wait_idle();

        // timeout, with alu_valid pulsed only during ISSUE
        issue_pulse = 1'b1;
        send(9, 9, 2, -1, acc);
        k = 1;
        while (!rsp_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("timeout_latency", 32'(k), 32'(TIMEOUT + 2));
        check("timeout_err", 32'({rsp_err, rsp_result}), 32'h10000);
        issue_pulse = 1'b0;
        wait_idle();
        check("timeout_no_count", 32'(op_count), 32'd4);

        // backpressure
        rr_dir = 1'b0;
        send(11, 22, 2, 2, acc);
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_a = N'($urandom); req_b = N'($urandom); req_op = 2'($urandom);
            @(posedge clk); #1;
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_operands", 32'({alu_a, alu_b, alu_op}), 32'({7'd11, 7'd22, 2'b10}));
        end
        check("bp_result", 32'(rsp_result), 32'd33);
        c0 = cyc;
        rr_dir = 1'b1;
        send(40, 50, 3, 0, acc2);
        check("bp_accept_cycle", 32'(acc2), 32'(c0 + 2));
        check("bp_new_operands", 32'({alu_a, alu_b}), 32'({7'd40, 7'd50}));
        wait_idle();

        // reset in the middle of WAIT
        send(5, 6, 2, -1, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_cnt = 16'h0000;
        check("rstmid_ready", 32'(req_ready), 32'd1);
        check("rstmid_outputs", 32'({alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_err}), 32'd0);
        check("rstmid_count", 32'(op_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(9, 4, 2, 1, acc);
        wait_idle();
        check("rstmid_recover", 32'(op_count), 32'd1);

        // counter wrap via preload
        force dut.op_count_q = 16'hFFFF;
        model_cnt = 16'hFFFF;
        #1;
        release dut.op_count_q;
        check("wrap_preload", 32'(op_count), 32'hFFFF);
        send(1, 1, 2, 0, acc);
        wait_idle();
        check("wrap_zero", 32'(op_count), 32'h0000);

        // randomized traffic
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 10)), acc);
        end
        wait_idle();
        rand_ready = 1'b0;
        @(posedge clk); #1;
        check("final_count", 32'(op_count), 32'(model_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
